bit_serializer: RTL
===================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: number of bits per parallel word; legal range WIDTH >= 2.
REQ-002 SHALL provide port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL provide port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL provide port in_data, input, WIDTH: parallel word from upstream.
REQ-005 SHALL provide port in_valid, input, 1: in_data holds a word to send.
REQ-006 SHALL provide port in_ready, output, 1: block can accept a word this cycle.
REQ-007 SHALL provide port x, output, 1: serial bit stream into the Mealy sequence detector's x input.
REQ-008 SHALL provide port x_valid, output, 1: x carries a real data bit this cycle.
REQ-009 SHALL provide port busy, output, 1: a word is in flight.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT and PARITY; PARITY SHALL exist only per REQ-027.
REQ-011 An accept SHALL occur on a rising edge where in_valid=1 and in_ready=1 and reset=0.
REQ-012 On an accept, SHALL load in_data into a WIDTH-bit shift register, set the bit counter to WIDTH-1 and enter SHIFT.
REQ-013 IDLE: in_ready=1, x=0, x_valid=0, busy=0.
REQ-014 SHIFT: x = shift-register MSB (MSB first), x_valid=1, busy=1; each edge shifts left by one and decrements the counter.
REQ-015 First bit SHALL appear on x in the cycle immediately after the accept edge (latency 1 clock).
REQ-016 in_ready SHALL be 0 in SHIFT, except in the last-bit cycle (counter==0) when parity is not compiled in.
REQ-017 At the end of the last bit of a frame: if an accept occurs, SHALL reload and continue in SHIFT with no gap cycle; otherwise SHALL go to IDLE.
REQ-018 x and x_valid SHALL be driven only from registers, never combinationally from inputs.
REQ-019 in_data SHALL be sampled only on the accept edge; later changes SHALL NOT affect the word in flight.
REQ-020 in_valid while in_ready=0 SHALL be ignored; upstream holds in_valid/in_data until accepted.
REQ-021 x SHALL be 0 whenever x_valid=0.
REQ-022 Frame length SHALL be exactly WIDTH clocks (WIDTH+1 with parity); counter width SHALL be clog2(WIDTH).

Reset
REQ-023 reset SHALL take priority over every other input, including a simultaneous accept.
REQ-024 One cycle after a reset edge: state=IDLE, in_ready=1, x=0, x_valid=0, busy=0; shift register and counter SHALL be 0.
REQ-025 reset mid-frame SHALL abort the frame; remaining bits SHALL be discarded, never resumed.
REQ-026 While reset is held, no accept SHALL occur.

Configuration
REQ-027 With macro BIT_SERIALIZER_PARITY_EN defined: after the last data bit, SHALL enter PARITY for one cycle with x = XOR of all WIDTH bits of the accepted word (even parity), x_valid=1, busy=1, in_ready=1; a back-to-back accept in PARITY SHALL follow REQ-017; in_ready SHALL be 0 in every SHIFT cycle.
REQ-028 Without BIT_SERIALIZER_PARITY_EN: the PARITY state and its logic SHALL be absent; the frame is data bits only, per REQ-016/017.

Verification
REQ-029 Reset, then accept 8'hA5 -> x = 1,0,1,0,0,1,0,1 on the 8 cycles after accept, x_valid=1 for exactly 8 cycles, then IDLE with x=0.
REQ-030 Accept 8'h26 feeding the Mealy detector -> x = 0,0,1,0,0,1,1,0; detector z matches its golden run for the same bit sequence.
REQ-031 in_valid held high with 8'h00 then 8'hFF (no parity) -> 16 contiguous x_valid=1 cycles, x = eight 0s then eight 1s, no gap.
REQ-032 Accept 8'hC3, assert reset during the 4th bit -> next cycle x_valid=0, x=0, in_ready=1; subsequent accept of 8'h81 -> x = 1,0,0,0,0,0,0,1.
REQ-033 While busy, toggle in_valid and change in_data to 8'hFF -> in-flight word unchanged; in_ready stays 0 until the last-bit cycle.
REQ-034 With BIT_SERIALIZER_PARITY_EN: 8'h07 -> 9 bits ending in parity 1; 8'h03 -> 9 bits ending in parity 0; x_valid=1 for 9 cycles each.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: loads a WIDTH-bit parallel word and sends it MSB first on x,
// one bit per clock, with x_valid marking real data bits.
// Optional: define BIT_SERIALIZER_PARITY_EN to append one even-parity bit per frame.
// Ports:
//   clock    - single clock, rising edge
//   reset    - synchronous, active-high
//   in_data  - parallel word from upstream (WIDTH bits)
//   in_valid - in_data holds a word to send
//   in_ready - block can accept a word this cycle
//   x        - serial bit stream
//   x_valid  - x carries a real data bit this cycle
//   busy     - a word is in flight
module bit_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             accept;
    logic             load;
    logic             in_ready_n;
    logic             x_n;
    logic             x_valid_n;
    logic             busy_n;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par;
    logic             par_n;
`endif

    // Next-state and next-output logic; outputs are precomputed so they can be registered.
    always_comb begin
        state_n    = state;
        sr_n       = sr;
        cnt_n      = cnt;
        load       = 1'b0;
        in_ready_n = 1'b0;
        x_n        = 1'b0;
        x_valid_n  = 1'b0;
        busy_n     = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_n      = par;
`endif
        accept     = in_valid && in_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                sr_n = {sr[WIDTH-2:0], 1'b0};
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_n = PARITY;
`else
                    // Last data bit: chain straight into the next word if one is taken now.
                    if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    load = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        if (load) begin
            state_n = SHIFT;
            sr_n    = in_data;
            cnt_n   = CW'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
            par_n   = ^in_data;
`endif
        end

        case (state_n)
            IDLE: begin
                in_ready_n = 1'b1;
            end
            SHIFT: begin
                x_n       = sr_n[WIDTH-1];
                x_valid_n = 1'b1;
                busy_n    = 1'b1;
`ifndef BIT_SERIALIZER_PARITY_EN
                in_ready_n = (cnt_n == '0);
`endif
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PARITY: begin
                x_n        = par_n;
                x_valid_n  = 1'b1;
                busy_n     = 1'b1;
                in_ready_n = 1'b1;
            end
`endif
            default: begin
                in_ready_n = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sr       <= '0;
            cnt      <= '0;
            in_ready <= 1'b1;
            x        <= 1'b0;
            x_valid  <= 1'b0;
            busy     <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            in_ready <= in_ready_n;
            x        <= x_n;
            x_valid  <= x_valid_n;
            busy     <= busy_n;
`ifdef BIT_SERIALIZER_PARITY_EN
            par      <= par_n;
`endif
        end
    end

endmodule
